// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end with prefetch FIFO and branch redirect
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [2:0]  fifo_count
);

  localparam int                PTR_W     = (DEPTH > 2) ? 2 : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [2:0]        DEPTH_CNT = 3'(DEPTH);
  localparam logic [15:0]       PC_INIT   = RESET_PC & 16'hFFFE;

  logic [15:0]      r_pc_q    [DEPTH];
  logic [15:0]      r_instr_q [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [2:0]       r_count;
  logic [15:0]      r_fetch_pc;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  assign w_empty = (r_count == 3'd0);
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_pop   = ~w_empty & instr_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still streams 1 instr/cycle.
  assign w_push  = ~redirect & (~w_full | w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= PC_INIT;
      r_count    <= 3'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_addr & 16'hFFFE;
      r_count    <= 3'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= next_ptr(r_wr_ptr);
        r_fetch_pc <= r_fetch_pc + 16'd2;
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible while r_count is non-zero.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]    <= r_fetch_pc;
      r_instr_q[r_wr_ptr] <= idata;
    end
  end

  assign iaddr       = r_fetch_pc;
  assign instr_valid = ~w_empty;
  assign instr       = w_empty ? 16'h0000 : r_instr_q[r_rd_ptr];
  assign instr_pc    = w_empty ? 16'h0000 : r_pc_q[r_rd_ptr];
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and random checks of ifetch_unit against a queue model
module tb_ifetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] iaddr;
  logic [15:0] idata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic [2:0]  fifo_count;

  logic [15:0] imem [0:32767];
  logic [31:0] m_q [$];
  logic [15:0] m_pc;
  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] exp_wrap [4];
  logic [15:0] exp_resume [4];

  always #5 clock = ~clock;

  assign idata = imem[iaddr[15:1]];

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .iaddr         (iaddr),
    .idata         (idata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .fifo_count    (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = RESET_PC & 16'hFFFE;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] head;
    logic        v;
    v    = (m_q.size() != 0);
    head = v ? m_q[0] : 32'h0;
    check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
    check({tag, ".instr"}, {16'b0, instr}, {16'b0, head[15:0]});
    check({tag, ".pc"}, {16'b0, instr_pc}, {16'b0, head[31:16]});
    check({tag, ".count"}, {29'b0, fifo_count}, 32'(m_q.size()));
    check({tag, ".iaddr"}, {16'b0, iaddr}, {16'b0, m_pc});
  endtask

  // Called just after a falling edge; returns after the next falling edge.
  task automatic step(input logic rdy, input logic rd, input logic [15:0] ra);
    logic pop;
    logic push;
    instr_ready   = rdy;
    redirect      = rd;
    redirect_addr = ra;
    pop  = (m_q.size() > 0) && rdy;
    push = !rd && ((m_q.size() < DEPTH) || pop);
    @(posedge clock);
    if (rd) begin
      m_q.delete();
      m_pc = ra & 16'hFFFE;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, imem[m_pc[15:1]]});
        m_pc = m_pc + 16'd2;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h6103;
    imem[1] = 16'h0043;
    exp_wrap   = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    exp_resume = '{16'h0006, 16'h0008, 16'h000A, 16'h000C};
    model_reset();

    @(negedge clock);
    @(negedge clock);
    check_outputs("reset");
    check("reset.iaddr_const", {16'b0, iaddr}, {16'b0, RESET_PC});
    reset_n = 1'b1;

    // 1: streaming from reset
    step(1'b1, 1'b0, 16'h0);
    check_outputs("t1a");
    check("t1.first_pc", {16'b0, instr_pc}, 32'h0000);
    check("t1.first_instr", {16'b0, instr}, 32'h6103);
    step(1'b1, 1'b0, 16'h0);
    check_outputs("t1b");
    check("t1.second_pc", {16'b0, instr_pc}, 32'h0002);
    check("t1.second_instr", {16'b0, instr}, 32'h0043);
    step(1'b1, 1'b0, 16'h0);
    check_outputs("t1c");

    // 2: back-pressure fills the FIFO and freezes fetch
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0);
      check_outputs("t2stall");
    end
    check("t2.count_full", {29'b0, fifo_count}, 32'(DEPTH));
    check("t2.iaddr_frozen", {16'b0, iaddr}, 32'h0008);
    check("t2.head_held", {16'b0, instr_pc}, 32'h0004);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0);
      check_outputs("t2resume");
      check("t2.resume_pc", {16'b0, instr_pc}, {16'b0, exp_resume[i]});
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0);
    check("t2.refull", {29'b0, fifo_count}, 32'(DEPTH));

    // 3: redirect on a full FIFO with a concurrent pop
    step(1'b1, 1'b1, 16'h0005);
    check_outputs("t3a");
    check("t3.count", {29'b0, fifo_count}, 32'h0);
    check("t3.valid", {31'b0, instr_valid}, 32'h0);
    check("t3.iaddr", {16'b0, iaddr}, 32'h0004);
    step(1'b0, 1'b0, 16'h0);
    check_outputs("t3b");
    check("t3.target_pc", {16'b0, instr_pc}, 32'h0004);

    // 4: address wrap
    step(1'b0, 1'b1, 16'hFFFC);
    check("t4.iaddr", {16'b0, iaddr}, 32'hFFFC);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0);
      check_outputs("t4");
      check("t4.wrap_pc", {16'b0, instr_pc}, {16'b0, exp_wrap[i]});
    end

    // 5: asynchronous reset between edges
    step(1'b1, 1'b1, 16'h0100);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5async");
    check("t5.iaddr", {16'b0, iaddr}, {16'b0, RESET_PC});
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    check_outputs("t5restart");
    check("t5.first_instr", {16'b0, instr}, 32'h6103);

    // 6: random ready/redirect
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), 16'($urandom));
      check_outputs("rnd");
      check("rnd.count_bound", {31'b0, (fifo_count <= 3'(DEPTH))}, 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
